// File: rtl/note_lane_engine.sv
// note_lane_engine: falling-note engine for the VGA rhythm game.
// Holds SLOTS notes per lane and spawns them from an external pattern memory.
// It moves notes down the screen, judges button presses against the hit
// window, and produces one registered pixel-on bit per lane.
// Optional feature macro: NOTE_LANE_MISS_PRESS_EN. When it is defined, a press
// with no note in the window counts as a miss and clears the combo.
module note_lane_engine #(
  parameter int LANES       = 3,
  parameter int SLOTS       = 3,
  parameter int SCREEN_H    = 480,
  parameter int LANE_W      = 200,
  parameter int LANE_GAP    = 20,
  parameter int NOTE_HALF   = 20,
  parameter int HIT_Y       = 440,
  parameter int HIT_WIN     = 16,
  parameter int PATTERN_LEN = 8,
  localparam int AW         = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_tick,
  input  logic             note_tick,
  input  logic             pause,
  input  logic [LANES-1:0] btn,
  output logic [AW-1:0]    pattern_addr,
  input  logic [LANES-1:0] pattern_data,
  input  logic [9:0]       CounterX,
  input  logic [9:0]       CounterY,
  output logic [LANES-1:0] pixel_on,
  output logic [7:0]       score,
  output logic [7:0]       miss,
  output logic [7:0]       combo,
  output logic             overflow
);

  localparam int          WIN_LO_I  = (HIT_Y > HIT_WIN) ? (HIT_Y - HIT_WIN) : 0;
  localparam logic [10:0] WIN_LO    = 11'(WIN_LO_I);
  localparam logic [10:0] WIN_HI    = 11'(HIT_Y + HIT_WIN);
  localparam logic [9:0]  RETIRE_Y  = 10'(SCREEN_H);
  localparam logic [10:0] HALF      = 11'(NOTE_HALF);
  localparam logic [AW-1:0] ADDR_LAST = AW'(PATTERN_LEN - 1);
  localparam int          LANE_PITCH = LANE_W + LANE_GAP;

  logic             slot_act [LANES][SLOTS];
  logic [9:0]       slot_y   [LANES][SLOTS];
  logic             act_n    [LANES][SLOTS];
  logic [9:0]       y_n      [LANES][SLOTS];

  logic [LANES-1:0] btn_prev;
  logic [LANES-1:0] press;
  logic [LANES-1:0] pix_n;
  logic             run;
  logic             do_move;
  logic             do_spawn;
  logic             drop;
  logic             found;
  logic [7:0]       hit_cnt;
  logic [7:0]       miss_cnt;
  int               cx;

  // Saturating 8-bit add so counters stick at 255 rather than wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // True when a note centre sits inside the inclusive hit window.
  function automatic logic in_window(input logic [9:0] y);
    return ({1'b0, y} >= WIN_LO) && ({1'b0, y} <= WIN_HI);
  endfunction

  assign run      = ~pause;
  assign do_move  = move_tick & run;
  assign do_spawn = note_tick & run;
  assign press    = btn & ~btn_prev & {LANES{run}};
  assign cx       = int'(CounterX);

  // Next slot state: hits, then moves/retires, then spawns, all judged on pre-cycle state.
  always_comb begin
    act_n    = slot_act;
    y_n      = slot_y;
    hit_cnt  = 8'd0;
    miss_cnt = 8'd0;
    drop     = 1'b0;
    found    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (press[l] && !found && slot_act[l][s] && in_window(slot_y[l][s])) begin
          act_n[l][s] = 1'b0;
          found       = 1'b1;
          hit_cnt     = hit_cnt + 8'd1;
        end
      end
`ifdef NOTE_LANE_MISS_PRESS_EN
      if (press[l] && !found) begin
        miss_cnt = miss_cnt + 8'd1;
      end
`else
`endif
      for (int s = 0; s < SLOTS; s++) begin
        if (do_move && slot_act[l][s] && act_n[l][s]) begin
          if (slot_y[l][s] == RETIRE_Y) begin
            act_n[l][s] = 1'b0;
            miss_cnt    = miss_cnt + 8'd1;
          end else begin
            y_n[l][s] = slot_y[l][s] + 10'd1;
          end
        end
      end
      found = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (do_spawn && pattern_data[l] && !found && !slot_act[l][s]) begin
          act_n[l][s] = 1'b1;
          y_n[l][s]   = 10'd0;
          found       = 1'b1;
        end
      end
      if (do_spawn && pattern_data[l] && !found) begin
        drop = 1'b1;
      end
    end
  end

  // Per-lane pixel coverage from the current beam position and active slots.
  always_comb begin
    pix_n = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_act[l][s] &&
            (cx >= l * LANE_PITCH) && (cx < l * LANE_PITCH + LANE_W) &&
            ({1'b0, CounterY} + HALF >= {1'b0, slot_y[l][s]}) &&
            ({1'b0, CounterY} <= {1'b0, slot_y[l][s]} + HALF)) begin
          pix_n[l] = 1'b1;
        end
      end
    end
  end

  // Register slot state, pattern address, counters, edge history and pixel bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < SLOTS; s++) begin
          slot_act[l][s] <= 1'b0;
          slot_y[l][s]   <= 10'd0;
        end
      end
      btn_prev     <= '0;
      pixel_on     <= '0;
      pattern_addr <= '0;
      score        <= 8'd0;
      miss         <= 8'd0;
      combo        <= 8'd0;
      overflow     <= 1'b0;
    end else begin
      slot_act <= act_n;
      slot_y   <= y_n;
      btn_prev <= btn;
      pixel_on <= pix_n;
      if (do_spawn) begin
        pattern_addr <= (pattern_addr == ADDR_LAST) ? '0 : pattern_addr + AW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      score <= sat_add(score, hit_cnt);
      miss  <= sat_add(miss, miss_cnt);
      combo <= (miss_cnt != 8'd0) ? 8'd0 : sat_add(combo, hit_cnt);
    end
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// tb_note_lane_engine: table-driven pixel vectors through a scoreboard queue,
// plus hand-written sequences for spawn, hit window, retire, overflow, pause
// and mid-operation reset.
module tb_note_lane_engine;

`ifdef NOTE_LANE_MISS_PRESS_EN
  localparam bit MISS_PRESS = 1'b1;
`else
  localparam bit MISS_PRESS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       move_tick;
  logic       note_tick;
  logic       pause;
  logic [2:0] btn;
  logic [2:0] pattern_addr;
  logic [2:0] pattern_data;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic [2:0] pixel_on;
  logic [7:0] score;
  logic [7:0] miss;
  logic [7:0] combo;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int exp_score;
  int exp_miss;
  int exp_combo;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] pix;
  } vec_t;

  typedef struct {
    int         id;
    logic [2:0] pix;
  } sb_t;

  vec_t vecs [25];
  sb_t  sb [$];

  note_lane_engine dut (
    .clk          (clk),
    .reset        (reset),
    .move_tick    (move_tick),
    .note_tick    (note_tick),
    .pause        (pause),
    .btn          (btn),
    .pattern_addr (pattern_addr),
    .pattern_data (pattern_data),
    .CounterX     (CounterX),
    .CounterY     (CounterY),
    .pixel_on     (pixel_on),
    .score        (score),
    .miss         (miss),
    .combo        (combo),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, "_score"}, int'(score), exp_score);
    checkOutput({name, "_miss"},  int'(miss),  exp_miss);
    checkOutput({name, "_combo"}, int'(combo), exp_combo);
  endtask

  task automatic applyStimulus(input int id);
    sb_t item;
    sb_t got;
    CounterX = 10'(vecs[id].x);
    CounterY = 10'(vecs[id].y);
    item.id  = id;
    item.pix = vecs[id].pix;
    sb.push_back(item);
    step();
    got = sb.pop_front();
    checkOutput($sformatf("pix_vec%0d", got.id), int'(pixel_on), int'(got.pix));
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(i);
    end
  endtask

  task automatic doReset();
    reset = 1'b1; move_tick = 1'b0; note_tick = 1'b0; pause = 1'b0;
    btn = 3'b000; pattern_data = 3'b000; CounterX = 10'd0; CounterY = 10'd0;
    step();
    reset = 1'b0;
    exp_score = 0; exp_miss = 0; exp_combo = 0;
  endtask

  task automatic spawn(input logic [2:0] pat);
    pattern_data = pat;
    note_tick    = 1'b1;
    step();
    note_tick    = 1'b0;
    pattern_data = 3'b000;
  endtask

  task automatic moveN(input int n);
    move_tick = 1'b1;
    repeat (n) step();
    move_tick = 1'b0;
  endtask

  task automatic press(input int lane);
    btn[lane] = 1'b1;
    step();
    btn[lane] = 1'b0;
    step();
  endtask

  task automatic modelMissPress();
    if (MISS_PRESS) begin
      exp_miss++;
      exp_combo = 0;
    end
  endtask

  task automatic modelHit();
    exp_score++;
    exp_combo++;
  endtask

  initial begin
    vecs[0]  = '{100, 10, 3'b001};
    vecs[1]  = '{540, 10, 3'b100};
    vecs[2]  = '{320, 10, 3'b000};
    vecs[3]  = '{100, 440, 3'b001};
    vecs[4]  = '{100, 440, 3'b000};
    vecs[5]  = '{100, 60, 3'b001};
    vecs[6]  = '{100, 30, 3'b001};
    vecs[7]  = '{100, 0, 3'b001};
    vecs[8]  = '{100, 85, 3'b000};
    vecs[9]  = '{100, 280, 3'b001};
    vecs[10] = '{100, 320, 3'b001};
    vecs[11] = '{100, 321, 3'b000};
    vecs[12] = '{100, 279, 3'b000};
    vecs[13] = '{199, 300, 3'b001};
    vecs[14] = '{200, 300, 3'b000};
    vecs[15] = '{220, 300, 3'b000};
    vecs[16] = '{100, 321, 3'b000};
    vecs[17] = '{100, 280, 3'b001};
    vecs[18] = '{100, 0, 3'b000};
    vecs[19] = '{100, 440, 3'b000};
    vecs[20] = '{100, 0, 3'b000};
    vecs[21] = '{320, 480, 3'b010};
    vecs[22] = '{320, 480, 3'b000};
    vecs[23] = '{100, 423, 3'b001};
    vecs[24] = '{100, 424, 3'b000};

    // Reset state
    doReset();
    checkOutput("reset_pixel", int'(pixel_on), 0);
    checkOutput("reset_addr", int'(pattern_addr), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkCounters("reset");

    // Spawn pattern 101 and walk the address around
    spawn(3'b101);
    checkOutput("spawn_addr1", int'(pattern_addr), 1);
    runVectors(0, 2);
    repeat (7) spawn(3'b000);
    checkOutput("addr_wrap", int'(pattern_addr), 0);

    // Note to the hit line, held press counts once
    doReset();
    spawn(3'b001);
    moveN(440);
    runVectors(3, 3);
    btn[0] = 1'b1;
    step();
    modelHit();
    checkCounters("hit440");
    repeat (5) step();
    checkCounters("hit_held");
    btn[0] = 1'b0;
    step();
    runVectors(4, 4);

    // Window boundaries and retire
    doReset();
    spawn(3'b001);
    moveN(423);
    runVectors(23, 23);
    press(0);
    modelMissPress();
    checkCounters("win_below");
    moveN(1);
    press(0);
    modelHit();
    checkCounters("win_lo_edge");
    runVectors(24, 24);
    spawn(3'b001);
    moveN(456);
    press(0);
    modelHit();
    checkCounters("win_hi_edge");
    spawn(3'b001);
    moveN(457);
    press(0);
    modelMissPress();
    checkCounters("win_above");
    moveN(24);
    exp_miss++;
    exp_combo = 0;
    checkCounters("retire_after_window");

    // Combo built, then cleared by a retired note in another lane
    doReset();
    spawn(3'b011);
    moveN(440);
    press(0);
    modelHit();
    moveN(40);
    runVectors(21, 21);
    checkCounters("pre_retire");
    moveN(1);
    exp_miss++;
    exp_combo = 0;
    checkCounters("retire");
    runVectors(22, 22);

    // Lane full: fourth spawn dropped
    doReset();
    spawn(3'b001);
    moveN(30);
    spawn(3'b001);
    moveN(30);
    spawn(3'b001);
    checkOutput("overflow_before", int'(overflow), 0);
    runVectors(5, 8);
    spawn(3'b001);
    checkOutput("overflow_after", int'(overflow), 1);
    runVectors(7, 7);

    // Press on an empty lane
    doReset();
    press(2);
    modelMissPress();
    checkCounters("empty_press");

    // Pixel geometry and pause freeze
    doReset();
    spawn(3'b001);
    moveN(300);
    runVectors(9, 15);
    pause = 1'b1;
    moveN(10);
    spawn(3'b001);
    runVectors(16, 18);
    checkOutput("pause_addr", int'(pattern_addr), 1);
    pause = 1'b0;

    // Press edge during pause is consumed
    doReset();
    spawn(3'b001);
    moveN(440);
    pause  = 1'b1;
    btn[0] = 1'b1;
    step();
    pause = 1'b0;
    step();
    step();
    checkCounters("pause_press");
    btn[0] = 1'b0;
    step();
    press(0);
    modelHit();
    checkCounters("after_pause_press");

    // Reset mid-operation with strobes active
    reset = 1'b1; note_tick = 1'b1; move_tick = 1'b1; pattern_data = 3'b111; btn = 3'b111;
    step();
    reset = 1'b0; note_tick = 1'b0; move_tick = 1'b0; pattern_data = 3'b000; btn = 3'b000;
    exp_score = 0; exp_miss = 0; exp_combo = 0;
    checkOutput("midreset_addr", int'(pattern_addr), 0);
    checkOutput("midreset_pixel", int'(pixel_on), 0);
    checkOutput("midreset_overflow", int'(overflow), 0);
    checkCounters("midreset");
    runVectors(19, 20);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
